// File: rtl/division_arbiter_if.sv
// rtl/division_arbiter_if.sv - request/response/divider bus shared by the division arbiter and its users
interface division_arbiter_if #(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_m;
  logic [NUM_REQ*WIDTH-1:0] req_d;
  logic [WIDTH-1:0]         div_m;
  logic [WIDTH-1:0]         div_d;
  logic [WIDTH-1:0]         div_q;
  logic [WIDTH-1:0]         div_r;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [NUM_REQ-1:0]       rsp_ready;
  logic [WIDTH-1:0]         rsp_q;
  logic [WIDTH-1:0]         rsp_r;
  logic                     rsp_dz;

  // Arbiter side
  modport slave (
    input  req_valid, req_m, req_d, div_q, div_r, rsp_ready,
    output req_ready, div_m, div_d, rsp_valid, rsp_q, rsp_r, rsp_dz
  );

  // Requesters plus shared divider side
  modport master (
    output req_valid, req_m, req_d, div_q, div_r, rsp_ready,
    input  req_ready, div_m, div_d, rsp_valid, rsp_q, rsp_r, rsp_dz
  );
endinterface

// File: rtl/division_arbiter.sv
// rtl/division_arbiter.sv - round-robin sharing of one combinational divider among NUM_REQ requesters
module division_arbiter #(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 2,
  parameter int SETTLE  = 1
) (
  input  logic              clk,
  input  logic              rst,
  division_arbiter_if.slave bus,
  output logic              busy
);
  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNTW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [IDXW:0]   NREQ_W   = (IDXW+1)'(NUM_REQ);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_REQ - 1);
  localparam logic [CNTW-1:0] CNT_INIT = CNTW'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

  state_t             r_state;
  logic [IDXW-1:0]    r_ptr;
  logic [IDXW-1:0]    r_owner;
  logic [CNTW-1:0]    r_cnt;
  logic [WIDTH-1:0]   r_div_m;
  logic [WIDTH-1:0]   r_div_d;
  logic [WIDTH-1:0]   r_rsp_q;
  logic [WIDTH-1:0]   r_rsp_r;
  logic               r_rsp_dz;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic               r_busy;

  logic               w_gnt_any;
  logic [IDXW-1:0]    w_gnt_idx;
  logic [IDXW:0]      w_sum;
  logic [IDXW-1:0]    w_cand;
  logic [NUM_REQ-1:0] w_gnt_hot;
  logic [NUM_REQ-1:0] w_owner_hot;
  logic [WIDTH-1:0]   w_gnt_m;
  logic [WIDTH-1:0]   w_gnt_d;
  logic [IDXW-1:0]    w_ptr_nxt;

  // First valid requester at or after the pointer, wrapping around
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_sum     = '0;
    w_cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (IDXW+1)'(k);
      if (w_sum >= NREQ_W) begin
        w_sum = w_sum - NREQ_W;
      end
      w_cand = w_sum[IDXW-1:0];
      if (!w_gnt_any && bus.req_valid[w_cand]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  // Decode grant/owner to one-hot and mux out the granted operands
  always_comb begin
    w_gnt_hot   = '0;
    w_owner_hot = '0;
    w_gnt_m     = '0;
    w_gnt_d     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_gnt_hot[k]   = (w_gnt_idx == IDXW'(k));
      w_owner_hot[k] = (r_owner == IDXW'(k));
      if (w_gnt_idx == IDXW'(k)) begin
        w_gnt_m = bus.req_m[k*WIDTH +: WIDTH];
        w_gnt_d = bus.req_d[k*WIDTH +: WIDTH];
      end
    end
    w_ptr_nxt = (w_gnt_idx == LAST_IDX) ? '0 : w_gnt_idx + 1'b1;
  end

  assign bus.req_ready = ((r_state == IDLE) && w_gnt_any) ? w_gnt_hot : '0;
  assign bus.div_m     = r_div_m;
  assign bus.div_d     = r_div_d;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_q     = r_rsp_q;
  assign bus.rsp_r     = r_rsp_r;
  assign bus.rsp_dz    = r_rsp_dz;
  assign busy          = r_busy;

  // Control FSM: grant and latch, hold divider inputs while settling, present response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_cnt       <= '0;
      r_div_m     <= '0;
      r_div_d     <= '0;
      r_rsp_q     <= '0;
      r_rsp_r     <= '0;
      r_rsp_dz    <= 1'b0;
      r_rsp_valid <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_any) begin
            r_owner <= w_gnt_idx;
            r_ptr   <= w_ptr_nxt;
            r_busy  <= 1'b1;
            if (w_gnt_m != '0) begin
              r_div_m <= w_gnt_m;
              r_div_d <= w_gnt_d;
              r_cnt   <= CNT_INIT;
              r_state <= ISSUE;
            end else begin
              // Zero divisor never reaches the divider; answer directly
              r_rsp_q     <= '1;
              r_rsp_r     <= w_gnt_d;
              r_rsp_dz    <= 1'b1;
              r_rsp_valid <= w_gnt_hot;
              r_state     <= RESP;
            end
          end
        end
        ISSUE: begin
          if (r_cnt == '0) begin
            r_rsp_q     <= bus.div_q;
            r_rsp_r     <= bus.div_r;
            r_rsp_dz    <= 1'b0;
            r_rsp_valid <= w_owner_hot;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready[r_owner]) begin
            r_rsp_valid <= '0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_division_arbiter.sv
// tb/tb_division_arbiter.sv - self-checking bench for division_arbiter
module tb_division_arbiter;
  localparam int W  = 4;
  localparam int N  = 2;
  localparam int S1 = 1;

  logic clk  = 1'b0;
  logic rst1 = 1'b1;
  logic rst3 = 1'b1;
  logic busy1, busy3;

  always #5 clk = ~clk;

  division_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus1 ();
  division_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus3 ();

  division_arbiter #(.WIDTH(W), .NUM_REQ(N), .SETTLE(S1)) u_dut1 (
    .clk(clk), .rst(rst1), .bus(bus1), .busy(busy1));
  division_arbiter #(.WIDTH(W), .NUM_REQ(N), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst3), .bus(bus3), .busy(busy3));

  // Shared combinational dividers
  assign bus1.div_q = (bus1.div_m == 4'd0) ? 4'hF : bus1.div_d / bus1.div_m;
  assign bus1.div_r = (bus1.div_m == 4'd0) ? bus1.div_d : bus1.div_d % bus1.div_m;
  assign bus3.div_q = (bus3.div_m == 4'd0) ? 4'hF : bus3.div_d / bus3.div_m;
  assign bus3.div_r = (bus3.div_m == 4'd0) ? bus3.div_d : bus3.div_d % bus3.div_m;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int grant_of(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (((v >> ((ptr + k) % N)) & 2'b01) != 2'b00) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // Transaction-level model of the SETTLE=1 instance
  bit         m_txn = 1'b0;
  int         m_owner = 0;
  int         m_ptr = 0;
  int         m_ready_at = 0;
  int         cyc = 0;
  logic [3:0] m_q = '0, m_r = '0, m_divm = '0, m_divd = '0;
  logic       m_dz = 1'b0;

  always @(posedge clk or posedge rst1) begin
    int mg;
    logic [3:0] mm, md;
    if (rst1) begin
      m_txn = 1'b0; m_ptr = 0; m_owner = 0; m_divm = '0; m_divd = '0;
    end else begin
      cyc++;
      if (m_txn) begin
        if (cyc > m_ready_at && ((bus1.rsp_ready >> m_owner) & 2'b01) != 2'b00) m_txn = 1'b0;
      end else begin
        mg = grant_of(bus1.req_valid, m_ptr);
        if (mg >= 0) begin
          m_txn = 1'b1; m_owner = mg; m_ptr = (mg + 1) % N;
          mm = 4'(bus1.req_m >> (mg * W));
          md = 4'(bus1.req_d >> (mg * W));
          if (mm == 4'd0) begin
            m_q = 4'hF; m_r = md; m_dz = 1'b1; m_ready_at = cyc;
          end else begin
            m_divm = mm; m_divd = md;
            m_q = md / mm; m_r = md % mm; m_dz = 1'b0; m_ready_at = cyc + S1;
          end
        end
      end
    end
  end

  // Compare DUT outputs against the model every cycle out of reset
  always @(negedge clk) begin
    int g;
    logic [31:0] erv;
    if (!rst1) begin
      erv = (m_txn && cyc >= m_ready_at) ? (32'd1 << m_owner) : 32'd0;
      g   = grant_of(bus1.req_valid, m_ptr);
      check("m_rsp_valid", bus1.rsp_valid, erv);
      check("m_busy", busy1, m_txn);
      check("m_req_ready", bus1.req_ready, (m_txn || g < 0) ? 32'd0 : (32'd1 << g));
      check("m_div_m", bus1.div_m, m_divm);
      check("m_div_d", bus1.div_d, m_divd);
      if (erv != 0) begin
        check("m_rsp_q", bus1.rsp_q, m_q);
        check("m_rsp_r", bus1.rsp_r, m_r);
        check("m_rsp_dz", bus1.rsp_dz, m_dz);
      end
    end
  end

  task automatic set_ops(input int i, input logic [3:0] m, input logic [3:0] d);
    logic [N*W-1:0] mask;
    mask = (N*W)'(4'hF) << (i * W);
    bus1.req_m = (bus1.req_m & ~mask) | ((N*W)'(m) << (i * W));
    bus1.req_d = (bus1.req_d & ~mask) | ((N*W)'(d) << (i * W));
  endtask

  task automatic transact(input int idx, input logic [3:0] m, input logic [3:0] d,
                          output logic [3:0] q, output logic [3:0] r, output int acc);
    bit ok;
    q = '0; r = '0; acc = 0;
    set_ops(idx, m, d);
    bus1.req_valid = N'(1 << idx);
    bus1.rsp_ready = N'(1 << idx);
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus1.req_ready[idx]) begin ok = 1'b1; break; end
    end
    check("accept_timeout", ok, 1'b1);
    tick();
    acc = cyc;
    bus1.req_valid = '0;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus1.rsp_valid[idx]) begin ok = 1'b1; q = bus1.rsp_q; r = bus1.rsp_r; break; end
    end
    check("rsp_timeout", ok, 1'b1);
    tick();
    bus1.rsp_ready = '0;
  endtask

  initial begin
    logic [3:0] q1, r1, q2, r2;
    int a1, a2;
    int order[$];
    bus1.req_valid = '0; bus1.req_m = '0; bus1.req_d = '0; bus1.rsp_ready = '0;
    bus3.req_valid = '0; bus3.req_m = '0; bus3.req_d = '0; bus3.rsp_ready = '0;
    repeat (2) tick();
    @(negedge clk);
    check("in_reset_rsp_valid", bus1.rsp_valid, 0);
    check("in_reset_busy", busy1, 0);
    tick();
    rst1 = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    check("rst_rsp_valid", bus1.rsp_valid, 0);
    check("rst_rsp_q", bus1.rsp_q, 0);
    check("rst_rsp_r", bus1.rsp_r, 0);
    check("rst_rsp_dz", bus1.rsp_dz, 0);
    check("rst_div_m", bus1.div_m, 0);
    check("rst_div_d", bus1.div_d, 0);
    check("rst_busy", busy1, 0);
    check("rst_req_ready", bus1.req_ready, 0);

    // Requester 0: 7 / 2
    tick();
    set_ops(0, 4'd2, 4'd7);
    bus1.req_valid = 2'b01;
    @(negedge clk);
    check("a_req_ready", bus1.req_ready, 2'b01);
    tick();
    bus1.req_valid = 2'b00;
    @(negedge clk);
    check("a_rsp_valid_early", bus1.rsp_valid, 2'b00);
    check("a_busy", busy1, 1);
    check("a_div_m", bus1.div_m, 4'd2);
    check("a_div_d", bus1.div_d, 4'd7);
    tick();
    @(negedge clk);
    check("a_rsp_valid", bus1.rsp_valid, 2'b01);
    check("a_q", bus1.rsp_q, 4'd3);
    check("a_r", bus1.rsp_r, 4'd1);
    check("a_dz", bus1.rsp_dz, 0);
    tick();
    bus1.rsp_ready = 2'b01;
    tick();
    bus1.rsp_ready = 2'b00;
    @(negedge clk);
    check("a_rsp_done", bus1.rsp_valid, 2'b00);
    check("a_idle", busy1, 0);

    // Requester 1: divide by zero
    tick();
    set_ops(1, 4'd0, 4'd9);
    bus1.req_valid = 2'b10;
    @(negedge clk);
    check("c_req_ready", bus1.req_ready, 2'b10);
    tick();
    bus1.req_valid = 2'b00;
    @(negedge clk);
    check("c_rsp_valid", bus1.rsp_valid, 2'b10);
    check("c_q", bus1.rsp_q, 4'hF);
    check("c_r", bus1.rsp_r, 4'h9);
    check("c_dz", bus1.rsp_dz, 1);
    check("c_div_m_kept", bus1.div_m, 4'd2);
    check("c_div_d_kept", bus1.div_d, 4'd7);
    bus1.rsp_ready = 2'b11;
    tick();
    bus1.rsp_ready = 2'b00;

    // Back-to-back from requester 0
    transact(0, 4'd4, 4'd6, q1, r1, a1);
    transact(0, 4'd4, 4'd9, q2, r2, a2);
    check("b_q1", q1, 4'd1);
    check("b_r1", r1, 4'd2);
    check("b_q2", q2, 4'd2);
    check("b_r2", r2, 4'd1);
    check("b_spacing", a2 - a1, 3);

    // Backpressure on requester 0 with requester 1 waiting
    tick();
    set_ops(0, 4'd3, 4'd8);
    bus1.req_valid = 2'b01;
    bus1.rsp_ready = 2'b00;
    @(negedge clk);
    check("p_req_ready0", bus1.req_ready, 2'b01);
    tick();
    set_ops(1, 4'd5, 4'd13);
    bus1.req_valid = 2'b10;
    bus1.rsp_ready = 2'b10;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("p_hold_valid", bus1.rsp_valid, 2'b01);
      check("p_hold_q", bus1.rsp_q, 4'd2);
      check("p_hold_r", bus1.rsp_r, 4'd2);
      check("p_hold_busy", busy1, 1);
      check("p_hold_ready", bus1.req_ready, 2'b00);
      tick();
    end
    bus1.rsp_ready = 2'b01;
    tick();
    @(negedge clk);
    check("p_req_ready1", bus1.req_ready, 2'b10);
    tick();
    bus1.req_valid = 2'b00;
    bus1.rsp_ready = 2'b10;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("p_rsp1_valid", bus1.rsp_valid, 2'b10);
    check("p_rsp1_q", bus1.rsp_q, 4'd2);
    check("p_rsp1_r", bus1.rsp_r, 4'd3);
    tick();
    bus1.rsp_ready = 2'b00;

    // Fairness after reset: both requesters continuously valid
    tick();
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    set_ops(0, 4'd3, 4'd10);
    set_ops(1, 4'd6, 4'd15);
    bus1.req_valid = 2'b11;
    bus1.rsp_ready = 2'b11;
    for (int t = 0; t < 40 && order.size() < 4; t++) begin
      @(negedge clk);
      if (bus1.req_ready != 2'b00) order.push_back(int'(bus1.req_ready[1]));
      if (bus1.rsp_valid[0]) begin
        check("f_q0", bus1.rsp_q, 4'd3);
        check("f_r0", bus1.rsp_r, 4'd1);
      end
      if (bus1.rsp_valid[1]) begin
        check("f_q1", bus1.rsp_q, 4'd2);
        check("f_r1", bus1.rsp_r, 4'd3);
      end
    end
    check("f_count", order.size(), 4);
    for (int i = 0; i < order.size(); i++) check($sformatf("f_grant%0d", i), order[i], i % 2);
    bus1.req_valid = 2'b00;
    repeat (4) tick();

    // Randomized traffic, checked by the model
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        bus1.req_valid[i] = ($urandom_range(0, 3) != 0);
        bus1.rsp_ready[i] = ($urandom_range(0, 4) < 3);
        set_ops(i, ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
                4'($urandom_range(0, 15)));
      end
    end
    bus1.req_valid = '0;
    bus1.rsp_ready = '1;
    repeat (6) tick();

    // SETTLE=3 instance: latency
    bus3.req_m = {4'd0, 4'd3};
    bus3.req_d = {4'd0, 4'd8};
    bus3.req_valid = 2'b01;
    @(negedge clk);
    check("s3_req_ready", bus3.req_ready, 2'b01);
    tick();
    bus3.req_valid = 2'b00;
    bus3.rsp_ready = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("s3_not_yet", bus3.rsp_valid, 2'b00);
      tick();
    end
    @(negedge clk);
    check("s3_rsp_valid", bus3.rsp_valid, 2'b01);
    check("s3_q", bus3.rsp_q, 4'd2);
    check("s3_r", bus3.rsp_r, 4'd2);
    tick();

    // SETTLE=3 instance: reset one cycle after accept
    bus3.req_m = {4'd5, 4'd0};
    bus3.req_d = {4'd13, 4'd0};
    bus3.req_valid = 2'b10;
    @(negedge clk);
    check("s3r_req_ready", bus3.req_ready, 2'b10);
    tick();
    bus3.req_valid = 2'b00;
    tick();
    rst3 = 1'b1;
    #1;
    check("s3r_rsp_valid", bus3.rsp_valid, 0);
    check("s3r_rsp_q", bus3.rsp_q, 0);
    check("s3r_rsp_r", bus3.rsp_r, 0);
    check("s3r_rsp_dz", bus3.rsp_dz, 0);
    check("s3r_div_m", bus3.div_m, 0);
    check("s3r_div_d", bus3.div_d, 0);
    check("s3r_busy", busy3, 0);
    repeat (2) tick();
    rst3 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("s3r_no_rsp", bus3.rsp_valid, 0);
      check("s3r_idle", busy3, 0);
      tick();
    end
    bus3.req_valid = 2'b11;
    @(negedge clk);
    check("s3r_ptr_restart", bus3.req_ready, 2'b01);
    tick();
    bus3.req_valid = 2'b00;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
